ula_op_sequencer: RTL and testbench
===================================

Name: ula_op_sequencer

Overview:
- Multi-cycle controller that sequences the team's 8-bit ULA datapath (ripple add/sub, bitwise AND, bitwise OR).
- Adds a valid/ready operand interface, registered results and flags, and an unsigned 8x8 multiply built by reusing the 8-bit adder over 8 shift-add iterations.
- Sits between the instruction decode logic and the ULA; one operation is in flight at a time.

Parameters:
- MUL_ITERS, 8, number of shift-add iterations for MUL; must equal the operand width (8).
- OP_W, 3, width of the op code field.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  sequencer can accept a request.
- op  in  OP_W  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101-111 illegal.
- a  in  8  operand A.
- b  in  8  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  16  operation result; upper byte is 0 except for MUL.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- flag_v  out  1  signed overflow flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - result=0, flag_c/z/v=0, out_valid=0, busy=0.
  - in_ready=1, because in_ready is decoded from state==IDLE.
- States: IDLE, EXEC, MUL, DONE.
- IDLE:
  - in_ready=1.
  - A request is accepted on an edge where in_valid&in_ready; a, b and op are latched on that edge (edge k).
  - On acceptance: op 000-011 or 101-111 go to EXEC; op 100 goes to MUL.
  - MUL entry clears the 16-bit accumulator and the iteration counter, and loads the multiplier from b.
- EXEC:
  - Combinational ULA result is registered at edge k+1; state goes to DONE.
  - ADD: a+b with cin=0.
  - SUB: a + ~b + 1, i.e. b XOR-inverted and cin=1.
  - AND: a&b. OR: a|b.
  - Illegal op: result=0, all flags=0.
- MUL:
  - Each edge (k+1 .. k+8): if the multiplier LSB is 1, add the multiplicand (a) to accumulator[15:8] through the 8-bit adder.
  - Then shift {carry, accumulator} right by 1, shift the multiplier right by 1, and increment the counter.
  - After iteration MUL_ITERS (edge k+8), the final value is written to result at edge k+9; state goes to DONE.
- DONE:
  - out_valid=1; result and flags hold stable while out_valid=1 && !out_ready.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - in_ready stays 0 in DONE, so a new request is never accepted on the same edge as the result handshake.
- Latency, accept edge to out_valid: 1 edge for ADD/SUB/AND/OR/illegal; 9 edges for MUL.
- Peak throughput: one ALU operation per 3 cycles.
- Width rules:
  - Non-MUL ops: result[15:8]=0.
  - MUL: result is the unsigned 16-bit product.
- Flags:
  - flag_z = (result==16'h0).
  - ADD: flag_c = carry out.
  - SUB: flag_c = adder carry out (1 means no borrow).
  - ADD/SUB: flag_v = signed overflow of the 8-bit operation.
  - AND/OR: flag_c=0, flag_v=0.
  - MUL: flag_c = (result[15:8]!=0), flag_v=0.
- Boundaries:
  - in_valid is ignored while busy; operand changes while busy have no effect.
  - out_ready while not in DONE is ignored.
  - rst_n asserted mid-MUL or mid-DONE: immediate return to the reset values; the pending result is discarded.

Optional Feature:
- Macro: ULA_SEQ_SAT_EN.
- Defined:
  - ADD clamps result to 8'hFF when carry out=1.
  - SUB clamps result to 8'h00 when the adder carry out=0 (borrow).
  - flag_c reports the raw carry; flag_v reports the raw overflow; flag_z is computed on the clamped result.
- Undefined: ADD and SUB wrap modulo 256; no clamping logic is present.

Test Plan:
- Reset mid-MUL: hold rst_n=0 during MUL iteration 4 -> out_valid=0, result=0, in_ready=1 immediately.
- ADD 8'h7F+8'h01 -> result=16'h0080, c=0, v=1, z=0, out_valid one edge after accept.
- SUB 8'h05-8'h05 -> result=0, z=1, c=1, v=0.
- SUB 8'h00-8'h01:
  - Macro undefined -> result=16'h00FF, c=0.
  - ULA_SEQ_SAT_EN defined -> result=0, z=1, c=0.
- MUL 8'hFF*8'hFF -> result=16'hFE01, c=1, z=0, out_valid at edge k+9.
- Backpressure: AND 8'hF0&8'h3C with out_ready=0 for 5 cycles -> result holds 16'h0030 and in_ready=0 throughout; then out_ready=1 -> IDLE, in_ready=1.

Source files
------------

// File: rtl/ula_op_sequencer.sv
// Multi-cycle sequencer for the 8-bit ULA: valid/ready request and result handshakes, add/sub/and/or, shift-add MUL.
// Optional saturating ADD/SUB is enabled by defining ULA_SEQ_SAT_EN.
module ula_op_sequencer #(
  parameter int MUL_ITERS = 8,
  parameter int OP_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [7:0]      a,
  input  logic [7:0]      b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     result,
  output logic            flag_c,
  output logic            flag_z,
  output logic            flag_v,
  output logic            busy
);

  localparam int CNT_W = $clog2(MUL_ITERS + 1);
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [8:0] add8(input logic [7:0] x, input logic [7:0] y, input logic cin);
    add8 = {1'b0, x} + {1'b0, y} + {8'h00, cin};
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      result_q, result_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_v_q, flag_v_d;
  logic             out_valid_q, out_valid_d;

  logic [7:0] add_x_s, add_y_s, res8_s;
  logic       add_cin_s, ovf_s;
  logic [8:0] sum_s;

  // The single 8-bit adder is shared: ALU ops in EXEC, partial-product accumulation in MUL.
  always_comb begin
    add_x_s   = 8'h00;
    add_y_s   = 8'h00;
    add_cin_s = 1'b0;
    case (state_q)
      S_EXEC: begin
        add_x_s   = a_q;
        add_y_s   = (op_q == OP_SUB) ? ~b_q : b_q;
        add_cin_s = (op_q == OP_SUB);
      end
      S_MUL: begin
        add_x_s = acc_q[15:8];
        add_y_s = b_q[0] ? a_q : 8'h00;
      end
      default: begin
        add_x_s   = 8'h00;
        add_y_s   = 8'h00;
        add_cin_s = 1'b0;
      end
    endcase
    sum_s = add8(add_x_s, add_y_s, add_cin_s);
    ovf_s = (add_x_s[7] == add_y_s[7]) && (sum_s[7] != add_x_s[7]);
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    flag_c_d    = flag_c_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;
    out_valid_d = out_valid_q;
    res8_s      = sum_s[7:0];
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          acc_d   = 16'h0000;
          cnt_d   = {CNT_W{1'b0}};
          state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        state_d     = S_DONE;
        out_valid_d = 1'b1;
        case (op_q)
          OP_ADD: begin
`ifdef ULA_SEQ_SAT_EN
            res8_s = sum_s[8] ? 8'hFF : sum_s[7:0];
`else
            res8_s = sum_s[7:0];
`endif
            result_d = {8'h00, res8_s};
            flag_c_d = sum_s[8];
            flag_v_d = ovf_s;
            flag_z_d = (res8_s == 8'h00);
          end
          OP_SUB: begin
`ifdef ULA_SEQ_SAT_EN
            res8_s = sum_s[8] ? sum_s[7:0] : 8'h00;
`else
            res8_s = sum_s[7:0];
`endif
            result_d = {8'h00, res8_s};
            flag_c_d = sum_s[8];
            flag_v_d = ovf_s;
            flag_z_d = (res8_s == 8'h00);
          end
          OP_AND: begin
            result_d = {8'h00, a_q & b_q};
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
            flag_z_d = ((a_q & b_q) == 8'h00);
          end
          OP_OR: begin
            result_d = {8'h00, a_q | b_q};
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
            flag_z_d = ((a_q | b_q) == 8'h00);
          end
          default: begin
            result_d = 16'h0000;
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
            flag_z_d = 1'b0;
          end
        endcase
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(MUL_ITERS)) begin
          result_d    = acc_q;
          flag_c_d    = (acc_q[15:8] != 8'h00);
          flag_v_d    = 1'b0;
          flag_z_d    = (acc_q == 16'h0000);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          // Carry out of the adder becomes the new MSB as {carry, acc} shifts right.
          acc_d = {sum_s, acc_q[7:1]};
          b_d   = {1'b0, b_q[7:1]};
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= {OP_W{1'b0}};
      acc_q       <= 16'h0000;
      cnt_q       <= {CNT_W{1'b0}};
      result_q    <= 16'h0000;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Self-checking bench for ula_op_sequencer: protocol/arithmetic model plus directed literal vectors.
module tb_ula_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_c, flag_z, flag_v, busy;

  int checks   = 0;
  int failures = 0;

  ula_op_sequencer #(.MUL_ITERS(8), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: returns {c, z, v, result[15:0]}.
  function automatic logic [18:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int r, sv;
    logic c, v;
    r = 0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: begin
        r  = int'(x) + int'(y);
        c  = (r > 255);
        r  = r % 256;
        sv = int'($signed(x)) + int'($signed(y));
        v  = (sv > 127) || (sv < -128);
`ifdef ULA_SEQ_SAT_EN
        if (c) r = 255;
`endif
      end
      3'd1: begin
        c  = (x >= y);
        r  = (int'(x) - int'(y) + 256) % 256;
        sv = int'($signed(x)) - int'($signed(y));
        v  = (sv > 127) || (sv < -128);
`ifdef ULA_SEQ_SAT_EN
        if (!c) r = 0;
`endif
      end
      3'd2: r = int'(x & y);
      3'd3: r = int'(x | y);
      3'd4: begin
        r = int'(x) * int'(y);
        c = (r > 255);
      end
      default: return 19'h0;
    endcase
    return {c, (r == 0), v, 16'(r)};
  endfunction

  logic        m_busy, m_ov;
  int          m_wait;
  logic [18:0] m_exp;

  // Transaction-level model: accept when idle, result appears after the op's latency, retires on out_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_ov   <= 1'b0;
      m_wait <= 0;
      m_exp  <= 19'h0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_wait <= (op == 3'd4) ? 9 : 1;
        m_exp  <= model(op, a, b);
      end
    end else if (!m_ov) begin
      if (m_wait == 1) m_ov <= 1'b1;
      m_wait <= m_wait - 1;
    end else if (out_ready) begin
      m_ov   <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  // Per-cycle comparison of DUT against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      chk("m_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov) begin
        chk("m_result", {16'b0, result}, {16'b0, m_exp[15:0]});
        chk("m_flags", {29'b0, flag_c, flag_z, flag_v}, {29'b0, m_exp[18], m_exp[17], m_exp[16]});
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_flags", {29'b0, flag_c, flag_z, flag_v}, 32'd0);
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] er, input logic ec, input logic ez, input logic ev,
                        input int lat, input int hold);
    int n;
    chk({nm, "_model_pin"}, {13'b0, model(o, x, y)}, {13'b0, ec, ez, ev, er});
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    // Junk request and operand changes while busy must be ignored.
    in_valid = 1'b1; op = 3'd4; a = 8'h5A; b = 8'hA5;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      failures++; checks++;
      $display("FAIL %s_timeout actual=no_out_valid expected=out_valid", nm);
      return;
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_result"}, {16'b0, result}, {16'b0, er});
    chk({nm, "_flags"}, {29'b0, flag_c, flag_z, flag_v}, {29'b0, ec, ez, ev});
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({nm, "_hold_result"}, {16'b0, result}, {16'b0, er});
        chk({nm, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({nm, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_retire_in_ready"}, {31'b0, in_ready}, 32'd1);
    chk({nm, "_retire_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00; out_ready = 1'b1;
    #1;
    chk_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1'b1, 1, 0);
    run_op("sub_05_05", 3'd1, 8'h05, 8'h05, 16'h0000, 1'b1, 1'b1, 1'b0, 1, 0);
`ifdef ULA_SEQ_SAT_EN
    run_op("sub_00_01", 3'd1, 8'h00, 8'h01, 16'h0000, 1'b0, 1'b1, 1'b0, 1, 0);
    run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 16'h00FF, 1'b1, 1'b0, 1'b0, 1, 0);
`else
    run_op("sub_00_01", 3'd1, 8'h00, 8'h01, 16'h00FF, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0, 1, 0);
`endif
    run_op("sub_80_01", 3'd1, 8'h80, 8'h01, 16'h007F, 1'b1, 1'b0, 1'b1, 1, 0);
    run_op("mul_ff_ff", 3'd4, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b0, 9, 0);
    run_op("mul_0d_0b", 3'd4, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op("mul_00_37", 3'd4, 8'h00, 8'h37, 16'h0000, 1'b0, 1'b1, 1'b0, 9, 0);
    run_op("illegal_5", 3'd5, 8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("and_bp",    3'd2, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1, 5);
    run_op("or_0f_f0",  3'd3, 8'h0F, 8'hF0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1, 0);

    // Reset asserted during MUL iteration 4 discards the pending product.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd4; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_mul_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 3'd0, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 1'b0, 1, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
